mrd_rdx2345_wrbank: RTL and testbench

//  Write-back stage directly downstream of the radix-2/3/4/5 DFT + twiddle stage.

---
 rtl/mrd_pkg.sv | 24 ++
 rtl/mrd_rdx2345_wrbank_if.sv | 31 +++
 rtl/mrd_wrbank_sel.sv | 37 +++
 rtl/mrd_rdx2345_wrbank.sv | 152 +++++++++++++++
 tb/tb_mrd_rdx2345_wrbank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mrd_pkg.sv
// Shared types and sizes for the radix-2/3/4/5 write-back bank stage.
package mrd_pkg;

    localparam int unsigned wDataInOut = 30;
    localparam int unsigned wBankAddr  = 8;
    localparam int unsigned wFrameLen  = 10;
    localparam int unsigned wBankIdx   = 3;
    localparam int unsigned NUM_LANES  = 5;
    localparam int unsigned NUM_BANKS  = 5;

    typedef struct packed {
        logic signed [wDataInOut-1:0] re;
        logic signed [wDataInOut-1:0] im;
        logic [wBankIdx-1:0]          bank_index;
        logic [wBankAddr-1:0]         bank_addr;
    } mrd_lane_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } mrd_wrbank_state_t;

endpackage

// File: rtl/mrd_rdx2345_wrbank_if.sv
// Beat input, bank write ports and status of the write-back stage.
interface mrd_rdx2345_wrbank_if;
    import mrd_pkg::*;

    logic                         start;
    logic [wFrameLen-1:0]         frame_len;
    logic                         in_val;
    logic signed [wDataInOut-1:0] in_real       [NUM_LANES];
    logic signed [wDataInOut-1:0] in_imag       [NUM_LANES];
    logic [wBankIdx-1:0]          in_bank_index [NUM_LANES];
    logic [wBankAddr-1:0]         in_bank_addr  [NUM_LANES];
    logic [NUM_BANKS-1:0]         wr_en;
    logic [wBankAddr-1:0]         wr_addr       [NUM_BANKS];
    logic [2*wDataInOut-1:0]      wr_data       [NUM_BANKS];
    logic                         busy;
    logic                         done;
    logic                         err_conflict;
    logic                         err_range;
    logic                         err_unexp;

    modport master (
        output start, frame_len, in_val, in_real, in_imag, in_bank_index, in_bank_addr,
        input  wr_en, wr_addr, wr_data, busy, done, err_conflict, err_range, err_unexp
    );

    modport slave (
        input  start, frame_len, in_val, in_real, in_imag, in_bank_index, in_bank_addr,
        output wr_en, wr_addr, wr_data, busy, done, err_conflict, err_range, err_unexp
    );

endinterface

// File: rtl/mrd_wrbank_sel.sv
// Per-bank priority selector: lowest lane whose bank index matches bank_i wins.
// Multi-hit output exists only when MRD_WRBANK_CHECK_EN is defined.
module mrd_wrbank_sel
    import mrd_pkg::*;
(
    input  logic [wBankIdx-1:0] idx_i [NUM_LANES],
    input  logic [wBankIdx-1:0] bank_i,
    output logic                hit_o,
    output logic [wBankIdx-1:0] lane_o
`ifdef MRD_WRBANK_CHECK_EN
    ,
    output logic                multi_o
`endif
);

    always_comb begin
        hit_o  = 1'b0;
        lane_o = '0;
`ifdef MRD_WRBANK_CHECK_EN
        multi_o = 1'b0;
`endif
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (idx_i[k] == bank_i) begin
                if (!hit_o) begin
                    hit_o  = 1'b1;
                    lane_o = wBankIdx'(k);
                end
`ifdef MRD_WRBANK_CHECK_EN
                else begin
                    multi_o = 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/mrd_rdx2345_wrbank.sv
// Write-back stage: routes 5-lane beats to 5 bank write ports and tracks frame length.
// MRD_WRBANK_CHECK_EN builds the sticky conflict/range/unexpected-beat error flags.
module mrd_rdx2345_wrbank
    import mrd_pkg::*;
(
    input logic                  clk,
    input logic                  rst,
    mrd_rdx2345_wrbank_if.slave  bus
);

    mrd_wrbank_state_t       state_q, state_d;
    logic [wFrameLen-1:0]    cnt_q, cnt_d;
    logic [wFrameLen-1:0]    len_q, len_d;
    logic [NUM_BANKS-1:0]    en_q, en_d;
    logic [wBankAddr-1:0]    addr_q [NUM_BANKS];
    logic [wBankAddr-1:0]    addr_d [NUM_BANKS];
    logic [2*wDataInOut-1:0] data_q [NUM_BANKS];
    logic [2*wDataInOut-1:0] data_d [NUM_BANKS];

    mrd_lane_t               lanes [NUM_LANES];
    logic [wBankIdx-1:0]     idx   [NUM_LANES];
    logic [NUM_BANKS-1:0]    hit;
    logic [wBankIdx-1:0]     sel   [NUM_BANKS];
    logic                    accept;

    always_comb begin
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            lanes[k].re         = bus.in_real[k];
            lanes[k].im         = bus.in_imag[k];
            lanes[k].bank_index = bus.in_bank_index[k];
            lanes[k].bank_addr  = bus.in_bank_addr[k];
            idx[k]              = lanes[k].bank_index;
        end
    end

`ifdef MRD_WRBANK_CHECK_EN
    logic [NUM_BANKS-1:0] multi;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_sel
        mrd_wrbank_sel u_sel (
            .idx_i   (idx),
            .bank_i  (wBankIdx'(b)),
            .hit_o   (hit[b]),
            .lane_o  (sel[b])
`ifdef MRD_WRBANK_CHECK_EN
            ,
            .multi_o (multi[b])
`endif
        );
    end

    // Exit at equality keeps the counter from ever wrapping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    len_d   = bus.frame_len;
                    cnt_d   = '0;
                    state_d = (bus.frame_len == '0) ? FLUSH : RUN;
                end
            end
            RUN: begin
                if (bus.in_val) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_d == len_q) state_d = FLUSH;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Unselected banks hold their last address/data.
    always_comb begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            en_d[b]   = accept & hit[b];
            addr_d[b] = addr_q[b];
            data_d[b] = data_q[b];
            if (en_d[b]) begin
                addr_d[b] = lanes[sel[b]].bank_addr;
                data_d[b] = {lanes[sel[b]].re, lanes[sel[b]].im};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            en_q    <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                addr_q[b] <= '0;
                data_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            en_q    <= en_d;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                addr_q[b] <= addr_d[b];
                data_q[b] <= data_d[b];
            end
        end
    end

    assign bus.wr_en   = en_q;
    assign bus.wr_addr = addr_q;
    assign bus.wr_data = data_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = (state_q == FLUSH);

`ifdef MRD_WRBANK_CHECK_EN
    logic conf_q, range_q, unexp_q;
    logic bad_idx;

    always_comb begin
        bad_idx = 1'b0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            if (idx[k] >= wBankIdx'(NUM_BANKS)) bad_idx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (state_q == IDLE && bus.start)) begin
            conf_q  <= 1'b0;
            range_q <= 1'b0;
            unexp_q <= 1'b0;
        end else begin
            if (accept && (|multi))              conf_q  <= 1'b1;
            if (accept && bad_idx)               range_q <= 1'b1;
            if (state_q == IDLE && bus.in_val)   unexp_q <= 1'b1;
        end
    end

    assign bus.err_conflict = conf_q;
    assign bus.err_range    = range_q;
    assign bus.err_unexp    = unexp_q;
`else
    assign bus.err_conflict = 1'b0;
    assign bus.err_range    = 1'b0;
    assign bus.err_unexp    = 1'b0;
`endif

endmodule

// File: tb/tb_mrd_rdx2345_wrbank.sv
// Scoreboard bench for mrd_rdx2345_wrbank: directed beats push expected writes, a monitor pops them.
module tb_mrd_rdx2345_wrbank;
    import mrd_pkg::*;

`ifdef MRD_WRBANK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    typedef struct packed {
        logic [NUM_BANKS-1:0]                         en;
        logic [NUM_BANKS-1:0][wBankAddr-1:0]          addr;
        logic [NUM_BANKS-1:0][2*wDataInOut-1:0]       data;
        logic                                         done;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t mon_e;

    logic [wBankIdx-1:0]          vidx  [NUM_LANES];
    logic [wBankAddr-1:0]         vaddr [NUM_LANES];
    logic signed [wDataInOut-1:0] vre   [NUM_LANES];
    logic signed [wDataInOut-1:0] vim   [NUM_LANES];
    logic [NUM_BANKS-1:0][wBankAddr-1:0]    hold_addr;
    logic [NUM_BANKS-1:0][2*wDataInOut-1:0] hold_data;

    always #5 clk = ~clk;

    mrd_rdx2345_wrbank_if bus();

    mrd_rdx2345_wrbank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lanes(input int i0, input int i1, input int i2, input int i3, input int i4,
                             input int abase, input int dbase);
        int ix[NUM_LANES];
        ix = '{i0, i1, i2, i3, i4};
        for (int k = 0; k < NUM_LANES; k++) begin
            vidx[k]  = wBankIdx'(ix[k]);
            vaddr[k] = wBankAddr'(abase + k);
            vre[k]   = wDataInOut'(dbase + k);
            vim[k]   = wDataInOut'(-(dbase + k));
        end
    endtask

    task automatic drive_lanes();
        for (int k = 0; k < NUM_LANES; k++) begin
            bus.in_bank_index[k] = vidx[k];
            bus.in_bank_addr[k]  = vaddr[k];
            bus.in_real[k]       = vre[k];
            bus.in_imag[k]       = vim[k];
        end
    endtask

    // src[b] is the hand-derived winning lane for bank b, -1 when no lane targets it
    task automatic send(input int s0, input int s1, input int s2, input int s3, input int s4,
                        input logic last);
        int   src[NUM_BANKS];
        exp_t e;
        src  = '{s0, s1, s2, s3, s4};
        e.en = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (src[b] >= 0) begin
                e.en[b]      = 1'b1;
                hold_addr[b] = vaddr[src[b]];
                hold_data[b] = {vre[src[b]], vim[src[b]]};
            end
        end
        e.addr = hold_addr;
        e.data = hold_data;
        e.done = last;
        q.push_back(e);
        drive_lanes();
        bus.in_val = 1'b1;
        tick(1);
        bus.in_val = 1'b0;
    endtask

    task automatic expect_done_only();
        exp_t e;
        e.en   = '0;
        e.addr = hold_addr;
        e.data = hold_data;
        e.done = 1'b1;
        q.push_back(e);
    endtask

    task automatic arm(input int len);
        bus.frame_len = wFrameLen'(len);
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && (bus.wr_en != '0 || bus.done === 1'b1)) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 64'({bus.wr_en, bus.done}), 64'(0));
            end else begin
                mon_e = q.pop_front();
                chk("wr_en", 64'(bus.wr_en), 64'(mon_e.en));
                chk("done", 64'(bus.done), 64'(mon_e.done));
                for (int b = 0; b < NUM_BANKS; b++) begin
                    chk($sformatf("wr_addr[%0d]", b), 64'(bus.wr_addr[b]), 64'(mon_e.addr[b]));
                    chk($sformatf("wr_data[%0d]", b), 64'(bus.wr_data[b]), 64'(mon_e.data[b]));
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.frame_len = '0;
        bus.in_val    = 1'b0;
        set_lanes(0, 0, 0, 0, 0, 0, 0);
        drive_lanes();
        hold_addr = '0;
        hold_data = '0;
        tick(2);
        chk("rst_wr_en", 64'(bus.wr_en), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_errs", 64'({bus.err_conflict, bus.err_range, bus.err_unexp}), 64'(0));
        chk("rst_wr_addr0", 64'(bus.wr_addr[0]), 64'(0));
        chk("rst_wr_data4", 64'(bus.wr_data[4]), 64'(0));
        rst = 1'b0;
        tick(1);

        // T1 identity routing, 3 beats
        arm(3);
        chk("t1_busy_run", 64'(bus.busy), 64'(1));
        for (int beat = 0; beat < 3; beat++) begin
            set_lanes(0, 1, 2, 3, 4, 10 * beat, 0);
            send(0, 1, 2, 3, 4, logic'(beat == 2));
        end
        chk("t1_busy_flush", 64'(bus.busy), 64'(1));
        tick(1);
        chk("t1_busy_after", 64'(bus.busy), 64'(0));

        // T2 permuted routing
        arm(1);
        set_lanes(4, 3, 2, 1, 0, 50, 100);
        send(4, 3, 2, 1, 0, 1'b1);
        tick(1);
        chk("t2_errs", 64'({bus.err_conflict, bus.err_range, bus.err_unexp}), 64'(0));

        // T3 conflict: lanes 0 and 1 both target bank 2
        arm(1);
        set_lanes(2, 2, 0, 1, 3, 60, 200);
        send(2, 3, 0, 4, -1, 1'b1);
        tick(3);
        chk("t3_err_conflict_sticky", 64'(bus.err_conflict), 64'(CHK));
        chk("t3_err_range", 64'(bus.err_range), 64'(0));

        // T4 out-of-range lane 4 with in_val gaps
        arm(3);
        chk("t4_conflict_cleared", 64'(bus.err_conflict), 64'(0));
        set_lanes(0, 1, 2, 3, 7, 70, 300);
        send(0, 1, 2, 3, -1, 1'b0);
        tick(2);
        chk("t4_busy_gap", 64'(bus.busy), 64'(1));
        set_lanes(0, 1, 2, 3, 7, 80, 310);
        send(0, 1, 2, 3, -1, 1'b0);
        tick(1);
        set_lanes(0, 1, 2, 3, 7, 90, 320);
        send(0, 1, 2, 3, -1, 1'b1);
        tick(1);
        chk("t4_err_range", 64'(bus.err_range), 64'(CHK));
        chk("t4_err_conflict", 64'(bus.err_conflict), 64'(0));

        // T5A zero-length frame
        expect_done_only();
        arm(0);
        chk("t5a_busy_flush", 64'(bus.busy), 64'(1));
        tick(1);
        chk("t5a_busy_after", 64'(bus.busy), 64'(0));

        // T5B beat while idle
        set_lanes(0, 1, 2, 3, 4, 110, 400);
        drive_lanes();
        bus.in_val = 1'b1;
        tick(1);
        bus.in_val = 1'b0;
        tick(1);
        chk("t5b_err_unexp", 64'(bus.err_unexp), 64'(CHK));
        chk("t5b_busy", 64'(bus.busy), 64'(0));

        // T5C second start mid-frame is ignored
        arm(2);
        set_lanes(0, 1, 2, 3, 4, 120, 500);
        send(0, 1, 2, 3, 4, 1'b0);
        bus.frame_len = wFrameLen'(7);
        bus.start     = 1'b1;
        tick(1);
        bus.start     = 1'b0;
        set_lanes(0, 1, 2, 3, 4, 130, 510);
        send(0, 1, 2, 3, 4, 1'b1);
        tick(1);
        chk("t5c_busy_after", 64'(bus.busy), 64'(0));

        // T6 reset after 2 of 5 beats, then a fresh 2-beat frame
        arm(5);
        set_lanes(0, 1, 2, 3, 4, 140, 600);
        send(0, 1, 2, 3, 4, 1'b0);
        set_lanes(0, 1, 2, 3, 4, 150, 610);
        send(0, 1, 2, 3, 4, 1'b0);
        tick(1);
        rst = 1'b1;
        tick(1);
        chk("t6_wr_en", 64'(bus.wr_en), 64'(0));
        chk("t6_busy", 64'(bus.busy), 64'(0));
        chk("t6_done", 64'(bus.done), 64'(0));
        for (int b = 0; b < NUM_BANKS; b++) begin
            chk($sformatf("t6_wr_addr%0d", b), 64'(bus.wr_addr[b]), 64'(0));
            chk($sformatf("t6_wr_data%0d", b), 64'(bus.wr_data[b]), 64'(0));
        end
        hold_addr = '0;
        hold_data = '0;
        rst = 1'b0;
        tick(1);
        arm(2);
        set_lanes(1, 0, 4, 7, 7, 160, 700);
        send(1, 0, -1, -1, 2, 1'b0);
        set_lanes(3, 3, 3, 3, 3, 170, 710);
        send(-1, -1, -1, 0, -1, 1'b1);
        tick(2);
        chk("t6_err_conflict", 64'(bus.err_conflict), 64'(CHK));
        chk("t6_err_range", 64'(bus.err_range), 64'(CHK));
        chk("t6_busy_after", 64'(bus.busy), 64'(0));

        tick(3);
        chk("queue_drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
